// File: rtl/nec_ir_receiver.sv
// NEC infrared remote-control receiver: measures mark/space lengths in 140.625 us ticks,
// decodes leader, 32-bit frames and repeat codes, and pulses ready/rpt/err (repeat is a reserved word, hence rpt).
module nec_ir_receiver #(
   parameter int          TICK_CYCLES = 7031,
   parameter bit          ADDR_CHECK  = 1'b0,
   parameter logic [15:0] ADDR        = 16'h0000,
   parameter logic [31:0] KEY_MASK    = 32'hCDDF_93FF,
   parameter bit          ALLOW_HIGH  = 1'b0,
   parameter bit          MSB_FIRST   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        serial,
   output logic [7:0]  tecla,
   output logic [15:0] custom,
   output logic        ready,
   output logic        rpt,
   output logic        err
);

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_CYCLES - 1);
   localparam logic [PW-1:0] PRESC_EDGE = PW'(1 % TICK_CYCLES);

   localparam logic [7:0] LEAD_MIN = 8'd56, LEAD_MAX = 8'd72;
   localparam logic [7:0] DATA_MIN = 8'd28, DATA_MAX = 8'd36;
   localparam logic [7:0] RPT_MIN  = 8'd12, RPT_MAX  = 8'd20;
   localparam logic [7:0] MARK_MIN = 8'd2,  MARK_MAX = 8'd6;
   localparam logic [7:0] ZERO_MIN = 8'd2,  ZERO_MAX = 8'd6;
   localparam logic [7:0] ONE_MIN  = 8'd10, ONE_MAX  = 8'd14;
   localparam logic [7:0] TIMEOUT  = 8'd80;

   typedef enum logic [2:0] {
      IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_STOP, CHECK
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic          line_q, line_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    dur_q, dur_d;
   logic [4:0]    bit_cnt_q, bit_cnt_d;
   logic [31:0]   sr_q, sr_d;
   logic          key_held_q, key_held_d;
   logic [7:0]    tecla_q, tecla_d;
   logic [15:0]   custom_q, custom_d;
   logic          ready_q, ready_d;
   logic          rpt_q, rpt_d;
   logic          err_q, err_d;

   logic          fall, rise, tick;
   logic [4:0]    bit_idx;
   logic [7:0]    cmd, cmd_inv, cmd_sum;
   logic          sum_ok, addr_ok, mask_ok;

   function automatic logic in_win(input logic [7:0] d, input logic [7:0] lo, input logic [7:0] hi);
      return (d >= lo) && (d <= hi);
   endfunction

   always_comb begin
      sync_d  = {sync_q[0], serial};
      line_d  = sync_q[1];
      fall    = line_q & ~sync_q[1];
      rise    = ~line_q & sync_q[1];
      tick    = (presc_q == PRESC_MAX);

      // The edge cycle counts as the first cycle of the new interval, so d equals whole ticks elapsed.
      if (fall || rise) begin
         presc_d = PRESC_EDGE;
         dur_d   = 8'd0;
      end else begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         dur_d   = (tick && dur_q != 8'hFF) ? dur_q + 8'd1 : dur_q;
      end

      bit_idx = {bit_cnt_q[4:3], MSB_FIRST ? ~bit_cnt_q[2:0] : bit_cnt_q[2:0]};
      cmd     = sr_q[23:16];
      cmd_inv = sr_q[31:24];
      cmd_sum = cmd + cmd_inv;
      sum_ok  = (cmd_sum == 8'hFF);
      addr_ok = !ADDR_CHECK || (sr_q[15:0] == ADDR);
      mask_ok = (cmd[7:5] != 3'd0) ? ALLOW_HIGH : KEY_MASK[cmd[4:0]];

      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sr_d       = sr_q;
      key_held_d = key_held_q;
      tecla_d    = tecla_q;
      custom_d   = custom_q;
      ready_d    = 1'b0;
      rpt_d      = 1'b0;
      err_d      = 1'b0;

      if (state_q != IDLE && dur_q == TIMEOUT) begin
         err_d   = 1'b1;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (fall) state_d = LEAD_MARK;
            LEAD_MARK: if (rise) begin
               if (in_win(dur_q, LEAD_MIN, LEAD_MAX)) state_d = LEAD_SPACE;
               else begin err_d = 1'b1; state_d = IDLE; end
            end
            LEAD_SPACE: if (fall) begin
               if (in_win(dur_q, DATA_MIN, DATA_MAX)) begin
                  state_d   = BIT_MARK;
                  bit_cnt_d = 5'd0;
               end else if (in_win(dur_q, RPT_MIN, RPT_MAX)) state_d = RPT_STOP;
               else begin err_d = 1'b1; state_d = IDLE; end
            end
            BIT_MARK: if (rise) begin
               if (in_win(dur_q, MARK_MIN, MARK_MAX)) state_d = BIT_SPACE;
               else begin err_d = 1'b1; state_d = IDLE; end
            end
            BIT_SPACE: if (fall) begin
               if (in_win(dur_q, ZERO_MIN, ZERO_MAX) || in_win(dur_q, ONE_MIN, ONE_MAX)) begin
                  sr_d[bit_idx] = in_win(dur_q, ONE_MIN, ONE_MAX);
                  bit_cnt_d     = bit_cnt_q + 5'd1;
                  state_d       = (bit_cnt_q == 5'd31) ? STOP_MARK : BIT_MARK;
               end else begin err_d = 1'b1; state_d = IDLE; end
            end
            STOP_MARK: if (rise) begin
               if (in_win(dur_q, MARK_MIN, MARK_MAX)) state_d = CHECK;
               else begin err_d = 1'b1; state_d = IDLE; end
            end
            RPT_STOP: if (rise) begin
               if (in_win(dur_q, MARK_MIN, MARK_MAX)) rpt_d = key_held_q;
               else err_d = 1'b1;
               state_d = IDLE;
            end
            CHECK: begin
               if (sum_ok && addr_ok && mask_ok) begin
                  tecla_d    = cmd;
                  custom_d   = sr_q[15:0];
                  ready_d    = 1'b1;
                  key_held_d = 1'b1;
               end else begin
                  err_d      = 1'b1;
                  key_held_d = 1'b0;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sync_q     <= 2'b11;
         line_q     <= 1'b1;
         presc_q    <= '0;
         dur_q      <= 8'd0;
         bit_cnt_q  <= 5'd0;
         sr_q       <= 32'd0;
         key_held_q <= 1'b0;
         tecla_q    <= 8'hFF;
         custom_q   <= 16'h0000;
         ready_q    <= 1'b0;
         rpt_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         line_q     <= line_d;
         presc_q    <= presc_d;
         dur_q      <= dur_d;
         bit_cnt_q  <= bit_cnt_d;
         sr_q       <= sr_d;
         key_held_q <= key_held_d;
         tecla_q    <= tecla_d;
         custom_q   <= custom_d;
         ready_q    <= ready_d;
         rpt_q      <= rpt_d;
         err_q      <= err_d;
      end
   end

   assign tecla  = tecla_q;
   assign custom = custom_q;
   assign ready  = ready_q;
   assign rpt    = rpt_q;
   assign err    = err_q;

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Bench for nec_ir_receiver: waveform-level stimulus, expected pulses scheduled from NEC timing
// rules and compared every cycle for two instances (default, and ALLOW_HIGH + address check).
module tb_nec_ir_receiver;
   localparam int T = 4;
   localparam logic [31:0] MASK = 32'hCDDF_93FF;

   logic clk = 1'b0, rst = 1'b1, serial = 1'b1;
   logic [7:0]  tecla0, tecla1;
   logic [15:0] custom0, custom1;
   logic ready0, rpt0, err0, ready1, rpt1, err1;

   nec_ir_receiver #(.TICK_CYCLES(T)) dut0 (
      .clk(clk), .rst(rst), .serial(serial), .tecla(tecla0), .custom(custom0),
      .ready(ready0), .rpt(rpt0), .err(err0));
   nec_ir_receiver #(.TICK_CYCLES(T), .ADDR_CHECK(1'b1), .ADDR(16'h00FF), .ALLOW_HIGH(1'b1)) dut1 (
      .clk(clk), .rst(rst), .serial(serial), .tecla(tecla1), .custom(custom1),
      .ready(ready1), .rpt(rpt1), .err(err1));

   always #5 clk = ~clk;

   int cyc = 0;
   logic rst_seen = 1'b1;
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   // kind bits: {ready, repeat, err}
   typedef struct { int cyc; logic [2:0] k0; logic [2:0] k1; logic [7:0] cmd; logic [15:0] cu; } ev_t;
   ev_t evq[$];

   int n_pass = 0, n_total = 0;
   int cnt_ready0 = 0, cnt_rpt0 = 0, cnt_err0 = 0, cnt_ready1 = 0, cnt_rpt1 = 0, cnt_err1 = 0;
   logic [7:0]  m_tecla0 = 8'hFF, m_tecla1 = 8'hFF;
   logic [15:0] m_custom0 = 16'h0, m_custom1 = 16'h0;
   logic held0 = 1'b0, held1 = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
   endtask

   always @(negedge clk) begin
      logic [2:0] e0, e1;
      ev_t ev;
      e0 = 3'b000;
      e1 = 3'b000;
      if (rst_seen) begin
         m_tecla0 = 8'hFF; m_custom0 = 16'h0; m_tecla1 = 8'hFF; m_custom1 = 16'h0;
      end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
         ev = evq.pop_front();
         e0 = ev.k0;
         e1 = ev.k1;
         if (ev.k0[2]) begin m_tecla0 = ev.cmd; m_custom0 = ev.cu; end
         if (ev.k1[2]) begin m_tecla1 = ev.cmd; m_custom1 = ev.cu; end
      end
      if (evq.size() > 0 && evq[0].cyc < cyc) begin
         check("stale_event", 32'(cyc), 32'(evq[0].cyc));
         void'(evq.pop_front());
      end
      check("dut0_outputs", {5'd0, tecla0, custom0, ready0, rpt0, err0}, {5'd0, m_tecla0, m_custom0, e0});
      check("dut1_outputs", {5'd0, tecla1, custom1, ready1, rpt1, err1}, {5'd0, m_tecla1, m_custom1, e1});
      cnt_ready0 += int'(ready0); cnt_rpt0 += int'(rpt0); cnt_err0 += int'(err0);
      cnt_ready1 += int'(ready1); cnt_rpt1 += int'(rpt1); cnt_err1 += int'(err1);
   end

   function automatic logic accepts(input logic [15:0] cu, input logic [7:0] cm, input logic [7:0] iv,
                                    input logic high, input logic achk);
      int s;
      logic key_ok;
      s = int'(cm) + int'(iv);
      if (cm >= 8'h20) key_ok = high;
      else key_ok = MASK[cm[4:0]];
      return (s % 256 == 255) && (!achk || cu == 16'h00FF) && key_ok;
   endfunction

   task automatic push(input int c, input logic [2:0] k0, input logic [2:0] k1,
                       input logic [7:0] cm, input logic [15:0] cu);
      ev_t ev;
      ev.cyc = c; ev.k0 = k0; ev.k1 = k1; ev.cmd = cm; ev.cu = cu;
      if (k0 != 3'b000 || k1 != 3'b000) evq.push_back(ev);
   endtask

   task automatic edge_to(input logic lvl, output int c);
      serial = lvl;
      c = cyc;
   endtask

   task automatic hold(input int ticks);
      repeat (ticks * T) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [15:0] cu, input logic [7:0] cm, input logic [7:0] iv,
                             input int bad_bit, input int rst_bit);
      int c;
      logic [31:0] w;
      logic a0, a1;
      w = {iv, cm, cu};
      edge_to(1'b0, c); hold($urandom_range(72, 56));
      edge_to(1'b1, c); hold($urandom_range(36, 28));
      for (int i = 0; i < 32; i++) begin
         if (i == rst_bit) begin
            rst = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            held0 = 1'b0;
            held1 = 1'b0;
            hold(40);
            return;
         end
         edge_to(1'b0, c); hold($urandom_range(6, 2));
         edge_to(1'b1, c);
         if (i == bad_bit) begin
            hold(15);
            edge_to(1'b0, c);
            push(c + 3, 3'b001, 3'b001, 8'h00, 16'h0);
            hold(4);
            edge_to(1'b1, c);
            hold(40);
            return;
         end
         hold(w[i] ? $urandom_range(14, 10) : $urandom_range(6, 2));
      end
      edge_to(1'b0, c); hold($urandom_range(6, 2));
      edge_to(1'b1, c);
      a0 = accepts(cu, cm, iv, 1'b0, 1'b0);
      a1 = accepts(cu, cm, iv, 1'b1, 1'b1);
      push(c + 4, a0 ? 3'b100 : 3'b001, a1 ? 3'b100 : 3'b001, cm, cu);
      held0 = a0;
      held1 = a1;
      hold(40);
   endtask

   task automatic send_repeat();
      int c;
      edge_to(1'b0, c); hold(64);
      edge_to(1'b1, c); hold(16);
      edge_to(1'b0, c); hold(4);
      edge_to(1'b1, c);
      push(c + 3, held0 ? 3'b010 : 3'b000, held1 ? 3'b010 : 3'b000, 8'h00, 16'h0);
      hold(40);
   endtask

   task automatic send_bad_leader();
      int c;
      edge_to(1'b0, c); hold($urandom_range(50, 40));
      edge_to(1'b1, c);
      push(c + 3, 3'b001, 3'b001, 8'h00, 16'h0);
      hold(40);
   endtask

   task automatic send_timeout();
      int c;
      edge_to(1'b0, c); hold(64);
      edge_to(1'b1, c); hold(32);
      edge_to(1'b0, c);
      push(c + 3 + 80 * T, 3'b001, 3'b001, 8'h00, 16'h0);
      hold(100);
      edge_to(1'b1, c); hold(40);
   endtask

   initial begin
      int b_r, b_p, b_e;
      logic [7:0] cm;
      logic [15:0] cu;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      hold(10);
      check("reset_tecla", 32'(tecla0), 32'h0000_00FF);
      check("reset_custom", 32'(custom0), 32'h0);

      send_repeat();
      check("repeat_after_reset_count", 32'(cnt_rpt0), 32'd0);

      send_frame(16'h00FF, 8'h16, 8'hE8, -1, -1);
      check("integrity_err_count", 32'(cnt_err0), 32'd1);
      check("integrity_tecla_kept", 32'(tecla0), 32'h0000_00FF);

      send_frame(16'h00FF, 8'h16, 8'hE9, -1, -1);
      check("valid_tecla", 32'(tecla0), 32'h16);
      check("valid_custom", 32'(custom0), 32'h00FF);
      check("valid_ready_count", 32'(cnt_ready0), 32'd1);
      check("valid_err_count", 32'(cnt_err0), 32'd1);

      send_repeat();
      check("repeat_count", 32'(cnt_rpt0), 32'd1);
      check("repeat_tecla", 32'(tecla0), 32'h16);

      send_frame(16'h00FF, 8'h0A, 8'hF5, -1, -1);
      check("mask_err_count", 32'(cnt_err0), 32'd2);

      send_frame(16'h00FF, 8'h40, 8'hBF, -1, -1);
      check("high_tecla_allow", 32'(tecla1), 32'h40);
      check("high_tecla_strict", 32'(tecla0), 32'h16);

      b_e = cnt_err0;
      send_timeout();
      check("timeout_err_count", 32'(cnt_err0 - b_e), 32'd1);
      send_frame(16'h00FF, 8'h1F, 8'hE0, -1, -1);
      check("after_timeout_tecla", 32'(tecla0), 32'h1F);

      b_e = cnt_err0;
      send_frame(16'h1234, 8'h00, 8'hFF, 5, -1);
      check("one_space_15_err", 32'(cnt_err0 - b_e), 32'd1);

      b_r = cnt_ready0; b_p = cnt_rpt0; b_e = cnt_err0;
      send_frame(16'h00FF, 8'h01, 8'hFE, -1, 12);
      check("midreset_tecla", 32'(tecla0), 32'h0000_00FF);
      check("midreset_no_pulse", 32'(cnt_ready0 - b_r + cnt_rpt0 - b_p + cnt_err0 - b_e), 32'd0);
      send_frame(16'h00FF, 8'h02, 8'hFD, -1, -1);
      check("after_midreset_tecla", 32'(tecla0), 32'h02);

      for (int n = 0; n < 12; n++) begin
         cm = 8'($urandom_range(255, 0));
         if ($urandom_range(1, 0) == 0) cm = {3'b000, cm[4:0]};
         cu = ($urandom_range(1, 0) == 0) ? 16'h00FF : 16'($urandom);
         case ($urandom_range(5, 0))
            0, 1: send_frame(cu, cm, ~cm, -1, -1);
            2:    send_frame(cu, cm, ~cm ^ (8'h01 << $urandom_range(7, 0)), -1, -1);
            3:    send_repeat();
            4:    send_bad_leader();
            default: send_frame(cu, cm, ~cm, int'($urandom_range(31, 0)), -1);
         endcase
      end
      hold(5);
      check("queue_drained", 32'(evq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule
